// File: rtl/scalar_mul_ctrl.sv
// Scalar-multiplication sequencer: left-to-right double-and-add driving an external point adder.
// All outputs registered; one adder command in flight, operands held until its finished pulse.
module scalar_mul_ctrl #(
  parameter int SCALAR_BITS = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [SCALAR_BITS-1:0] i_scalar,
  input  logic [254:0]           i_px,
  input  logic [254:0]           i_py,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_infinity,
  output logic [254:0]           o_x,
  output logic [254:0]           o_y,
  output logic [254:0]           o_z,
  output logic [254:0]           o_t,
  output logic                   o_pa_start,
  output logic                   o_pa_doubling,
  output logic                   o_pa_initial,
  output logic [254:0]           o_pa_x1,
  output logic [254:0]           o_pa_y1,
  output logic [254:0]           o_pa_z1,
  output logic [254:0]           o_pa_t1,
  output logic [254:0]           o_pa_x2,
  output logic [254:0]           o_pa_y2,
  output logic [254:0]           o_pa_z2,
  output logic [254:0]           o_pa_t2,
  input  logic [254:0]           i_pa_x3,
  input  logic [254:0]           i_pa_y3,
  input  logic [254:0]           i_pa_z3,
  input  logic [254:0]           i_pa_t3,
  input  logic                   i_pa_finished
);

  localparam int CW = $clog2(SCALAR_BITS + 1);

  typedef struct packed {
    logic [254:0] x;
    logic [254:0] y;
    logic [254:0] z;
    logic [254:0] t;
  } pt_t;

  typedef enum logic [3:0] {
    IDLE, INIT, WAIT_INIT, SCAN, NEXT, DBL, WAIT_DBL, ADD, WAIT_ADD, DONE
  } state_t;

  state_t                 state_q;
  logic [SCALAR_BITS-1:0] sreg_q;
  logic [CW-1:0]          cnt_q;
  pt_t                    a_q, b_q, res_q, op1_q, op2_q;
  logic                   busy_q, done_q, inf_q, start_q, dbl_q, ini_q;
  pt_t                    pa_res;

  assign pa_res = {i_pa_x3, i_pa_y3, i_pa_z3, i_pa_t3};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      inf_q   <= 1'b0;
      start_q <= 1'b0;
      dbl_q   <= 1'b0;
      ini_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: if (i_start) begin
          sreg_q <= i_scalar;
          cnt_q  <= CW'(SCALAR_BITS);
          busy_q <= 1'b1;
          if (i_scalar == '0) begin
            state_q <= DONE;
            inf_q   <= 1'b1;
            res_q   <= '0;
            done_q  <= 1'b1;
          end else begin
            state_q <= INIT;
            inf_q   <= 1'b0;
            start_q <= 1'b1;
            ini_q   <= 1'b1;
            dbl_q   <= 1'b0;
            op1_q   <= {i_px, i_py, 255'd0, 255'd0};
            op2_q   <= '0;
          end
        end
        INIT: state_q <= WAIT_INIT;
        WAIT_INIT: if (i_pa_finished) begin
          a_q     <= pa_res;
          b_q     <= pa_res;
          state_q <= SCAN;
        end
        // Consume bits down to and including the leading one.
        SCAN: begin
          sreg_q <= sreg_q << 1;
          cnt_q  <= cnt_q - CW'(1);
          if (sreg_q[SCALAR_BITS-1]) state_q <= NEXT;
        end
        NEXT: if (cnt_q == '0) begin
          state_q <= DONE;
          done_q  <= 1'b1;
          res_q   <= a_q;
        end else begin
          state_q <= DBL;
          start_q <= 1'b1;
          ini_q   <= 1'b0;
          dbl_q   <= 1'b1;
          op1_q   <= a_q;
          op2_q   <= a_q;
        end
        DBL: state_q <= WAIT_DBL;
        WAIT_DBL: if (i_pa_finished) begin
          a_q    <= pa_res;
          sreg_q <= sreg_q << 1;
          cnt_q  <= cnt_q - CW'(1);
          if (sreg_q[SCALAR_BITS-1]) begin
            // Accumulator is being updated this edge, so feed the fresh result.
            state_q <= ADD;
            start_q <= 1'b1;
            ini_q   <= 1'b0;
            dbl_q   <= 1'b0;
            op1_q   <= pa_res;
            op2_q   <= b_q;
          end else begin
            state_q <= NEXT;
          end
        end
        ADD: state_q <= WAIT_ADD;
        WAIT_ADD: if (i_pa_finished) begin
          a_q     <= pa_res;
          state_q <= NEXT;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_infinity    = inf_q;
  assign o_x           = res_q.x;
  assign o_y           = res_q.y;
  assign o_z           = res_q.z;
  assign o_t           = res_q.t;
  assign o_pa_start    = start_q;
  assign o_pa_doubling = dbl_q;
  assign o_pa_initial  = ini_q;
  assign o_pa_x1       = op1_q.x;
  assign o_pa_y1       = op1_q.y;
  assign o_pa_z1       = op1_q.z;
  assign o_pa_t1       = op1_q.t;
  assign o_pa_x2       = op2_q.x;
  assign o_pa_y2       = op2_q.y;
  assign o_pa_z2       = op2_q.z;
  assign o_pa_t2       = op2_q.t;

endmodule
